// File: rtl/code_verifier.sv
// code_verifier: buffers keypad digits and checks them against a stored password in constant time
// Ports:
//    clock, reset          system clock; asynchronous active-high reset
//    digit_valid, digit    keypad digit strobe and value
//    compare, clear        lock-controller requests: check the buffer / empty the buffer
//    pw_set, pw_length     stored password (digit i at [i*DIGIT_W +: DIGIT_W]) and its length
//    num_inputs, overflow  digits held in the buffer; sticky "digit dropped on full buffer"
//    busy                  high while a check is in flight
//    match, mismatch       one-cycle verdict pulses
//    locked, fail_count    lockout in progress; consecutive mismatches so far
module code_verifier #(
   parameter int DIGIT_W      = 2,
   parameter int MAX_LEN      = 8,
   parameter int LEN_W        = 4,
   parameter int MAX_ATTEMPTS = 3,
   parameter int LOCKOUT_CYC  = 1000
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       digit_valid,
   input  logic [DIGIT_W-1:0]         digit,
   input  logic                       compare,
   input  logic                       clear,
   input  logic [MAX_LEN*DIGIT_W-1:0] pw_set,
   input  logic [LEN_W-1:0]           pw_length,
   output logic [LEN_W-1:0]           num_inputs,
   output logic                       overflow,
   output logic                       busy,
   output logic                       match,
   output logic                       mismatch,
   output logic                       locked,
   output logic [LEN_W-1:0]           fail_count
);
   localparam int IDX_W = $clog2(MAX_LEN);
   localparam int CNT_W = $clog2(LOCKOUT_CYC + 1);
   typedef enum logic [1:0] {IDLE, CHECK, RESULT, LOCKOUT} state_t;
   state_t             state_q, state_d;
   logic [DIGIT_W-1:0] dig_q [MAX_LEN];
   logic [DIGIT_W-1:0] dig_d [MAX_LEN];
   logic [DIGIT_W-1:0] pw_q [MAX_LEN];
   logic [DIGIT_W-1:0] pw_d [MAX_LEN];
   logic [LEN_W-1:0]   num_q, num_d, slen_q, slen_d, scnt_q, scnt_d, fail_q, fail_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               eq_q, eq_d, ovf_q, ovf_d, busy_q, busy_d;
   logic               match_q, match_d, mis_q, mis_d, locked_q, locked_d;
   logic               ok;
   // Length checks use only the snapshot, so the live password inputs cannot disturb a check.
   assign ok = eq_q && (scnt_q == slen_q) && (slen_q != '0) && (slen_q <= LEN_W'(MAX_LEN));
   always_comb begin
      state_d  = state_q;
      dig_d    = dig_q;
      pw_d     = pw_q;
      num_d    = num_q;
      slen_d   = slen_q;
      scnt_d   = scnt_q;
      fail_d   = fail_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      eq_d     = eq_q;
      ovf_d    = ovf_q;
      match_d  = 1'b0;
      mis_d    = 1'b0;
      // busy trails the state by one edge so it covers exactly the check and verdict cycles.
      busy_d   = (state_q == CHECK) || (state_q == RESULT);
      case (state_q)
         IDLE: begin
            if (compare) begin
               for (int i = 0; i < MAX_LEN; i++) pw_d[i] = pw_set[i*DIGIT_W +: DIGIT_W];
               slen_d  = pw_length;
               scnt_d  = num_q;
               idx_d   = '0;
               eq_d    = 1'b1;
               state_d = CHECK;
            end else if (clear) begin
               num_d = '0;
               ovf_d = 1'b0;
            end else if (digit_valid) begin
               if (num_q < LEN_W'(MAX_LEN)) begin
                  dig_d[num_q[IDX_W-1:0]] = digit;
                  num_d = num_q + LEN_W'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end
         CHECK: begin
            // Every position is visited regardless of length so timing leaks nothing.
            if ((LEN_W'(idx_q) < slen_q) && (dig_q[idx_q] != pw_q[idx_q])) eq_d = 1'b0;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(MAX_LEN - 1)) state_d = RESULT;
         end
         RESULT: begin
            match_d = ok;
            mis_d   = !ok;
            num_d   = '0;
            ovf_d   = 1'b0;
            if (ok) begin
               fail_d  = '0;
               state_d = IDLE;
            end else begin
               fail_d  = (fail_q == LEN_W'(MAX_ATTEMPTS)) ? fail_q : fail_q + LEN_W'(1);
               state_d = (fail_d == LEN_W'(MAX_ATTEMPTS)) ? LOCKOUT : IDLE;
               cnt_d   = CNT_W'(LOCKOUT_CYC - 1);
            end
         end
         default: begin
            if (cnt_q == '0) begin
               fail_d  = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      endcase
      locked_d = (state_d == LOCKOUT);
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         dig_q    <= '{default: '0};
         pw_q     <= '{default: '0};
         num_q    <= '0;
         slen_q   <= '0;
         scnt_q   <= '0;
         fail_q   <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         eq_q     <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         match_q  <= 1'b0;
         mis_q    <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         dig_q    <= dig_d;
         pw_q     <= pw_d;
         num_q    <= num_d;
         slen_q   <= slen_d;
         scnt_q   <= scnt_d;
         fail_q   <= fail_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         eq_q     <= eq_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         match_q  <= match_d;
         mis_q    <= mis_d;
         locked_q <= locked_d;
      end
   end
   assign num_inputs = num_q;
   assign overflow   = ovf_q;
   assign busy       = busy_q;
   assign match      = match_q;
   assign mismatch   = mis_q;
   assign locked     = locked_q;
   assign fail_count = fail_q;
endmodule

// File: tb/tb_code_verifier.sv
// tb_code_verifier: directed self-checking bench for code_verifier (MAX_LEN=8, 3 attempts, 5-cycle lockout)
module tb_code_verifier;
   localparam logic [15:0] PW = 16'h0027;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        digit_valid = 1'b0;
   logic [1:0]  digit = '0;
   logic        compare = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] pw_set = PW;
   logic [3:0]  pw_length = 4'd4;
   logic [3:0]  num_inputs, fail_count;
   logic        overflow, busy, match, mismatch, locked;
   int          n_cmp = 0;
   int          n_bad = 0;
   code_verifier #(
      .DIGIT_W(2), .MAX_LEN(8), .LEN_W(4), .MAX_ATTEMPTS(3), .LOCKOUT_CYC(5)
   ) dut (
      .clock(clock), .reset(reset), .digit_valid(digit_valid), .digit(digit),
      .compare(compare), .clear(clear), .pw_set(pw_set), .pw_length(pw_length),
      .num_inputs(num_inputs), .overflow(overflow), .busy(busy), .match(match),
      .mismatch(mismatch), .locked(locked), .fail_count(fail_count)
   );
   always #5 clock = ~clock;
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic strobe(input logic [1:0] d);
      digit_valid = 1'b1;
      digit = d;
      step();
      digit_valid = 1'b0;
   endtask
   task automatic enter_code(input int n, input logic [15:0] digs);
      logic [15:0] v;
      v = digs;
      for (int i = 0; i < n; i++) strobe(v[i*2 +: 2]);
   endtask
   // Issues compare (optionally with a coincident digit strobe), applies pw_mid/len_mid
   // right after the snapshot edge, and follows the check to the verdict edge k+9.
   task automatic run_compare(input logic dv, input logic [15:0] pw_mid, input logic [3:0] len_mid,
                              output logic m, output logic mm, output logic bad);
      bad = 1'b0;
      compare = 1'b1;
      digit_valid = dv;
      digit = 2'd0;
      step();
      compare = 1'b0;
      digit_valid = 1'b0;
      pw_set = pw_mid;
      pw_length = len_mid;
      if (busy !== 1'b0 || match !== 1'b0 || mismatch !== 1'b0) bad = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         step();
         if (busy !== 1'b1) bad = 1'b1;
         if (i < 9 && (match !== 1'b0 || mismatch !== 1'b0)) bad = 1'b1;
      end
      m = match;
      mm = mismatch;
   endtask
   task automatic test_reset();
      step();
      step();
      n_cmp++; if ({num_inputs, overflow, busy, match, mismatch, locked, fail_count} !== 13'd0) begin n_bad++; $display("FAIL reset_held: got %h want 0", {num_inputs, overflow, busy, match, mismatch, locked, fail_count}); end
      reset = 1'b0;
      step();
      n_cmp++; if (num_inputs !== 4'd0) begin n_bad++; $display("FAIL reset_num: got %0d want 0", num_inputs); end
      n_cmp++; if (fail_count !== 4'd0) begin n_bad++; $display("FAIL reset_fail: got %0d want 0", fail_count); end
      n_cmp++; if ({overflow, busy, match, mismatch, locked} !== 5'd0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {overflow, busy, match, mismatch, locked}); end
   endtask
   task automatic test_match();
      logic m, mm, bad;
      enter_code(4, PW);
      n_cmp++; if (num_inputs !== 4'd4) begin n_bad++; $display("FAIL t1_num: got %0d want 4", num_inputs); end
      run_compare(1'b0, PW, 4'd4, m, mm, bad);
      n_cmp++; if ({m, mm} !== 2'b10) begin n_bad++; $display("FAIL t1_verdict: got %b want 10", {m, mm}); end
      n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL t1_timing: got %b want 0", bad); end
      n_cmp++; if (num_inputs !== 4'd0) begin n_bad++; $display("FAIL t1_num_after: got %0d want 0", num_inputs); end
      n_cmp++; if (fail_count !== 4'd0) begin n_bad++; $display("FAIL t1_fail: got %0d want 0", fail_count); end
      step();
      n_cmp++; if ({busy, match, mismatch} !== 3'b000) begin n_bad++; $display("FAIL t1_pulse_end: got %b want 000", {busy, match, mismatch}); end
   endtask
   task automatic test_mismatch();
      logic m, mm, bad;
      enter_code(3, PW);
      run_compare(1'b0, PW, 4'd4, m, mm, bad);
      n_cmp++; if ({m, mm, bad} !== 3'b010) begin n_bad++; $display("FAIL t2_short: got %b want 010", {m, mm, bad}); end
      n_cmp++; if (fail_count !== 4'd1) begin n_bad++; $display("FAIL t2_fail1: got %0d want 1", fail_count); end
      enter_code(5, PW);
      run_compare(1'b0, PW, 4'd4, m, mm, bad);
      n_cmp++; if ({m, mm, bad} !== 3'b010) begin n_bad++; $display("FAIL t2_long: got %b want 010", {m, mm, bad}); end
      n_cmp++; if (fail_count !== 4'd2) begin n_bad++; $display("FAIL t2_fail2: got %0d want 2", fail_count); end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL t2_locked: got %b want 0", locked); end
      enter_code(4, PW);
      run_compare(1'b0, PW, 4'd4, m, mm, bad);
      n_cmp++; if ({m, mm, fail_count} !== 6'b10_0000) begin n_bad++; $display("FAIL t2_recover: got %b want 100000", {m, mm, fail_count}); end
   endtask
   task automatic test_lockout();
      logic m, mm, bad;
      int cycles;
      for (int a = 0; a < 3; a++) begin
         enter_code(2, 16'h0003);
         run_compare(1'b0, PW, 4'd4, m, mm, bad);
         n_cmp++; if ({m, mm, bad} !== 3'b010) begin n_bad++; $display("FAIL t3_wrong%0d: got %b want 010", a, {m, mm, bad}); end
      end
      n_cmp++; if ({locked, fail_count} !== 5'b1_0011) begin n_bad++; $display("FAIL t3_enter: got locked=%b fail=%0d want locked=1 fail=3", locked, fail_count); end
      cycles = 1;
      digit = 2'd3;
      while (locked === 1'b1 && cycles < 20) begin
         digit_valid = 1'b1;
         compare = cycles[0];
         clear = 1'b0;
         step();
         if (locked === 1'b1) cycles++;
      end
      digit_valid = 1'b0;
      compare = 1'b0;
      n_cmp++; if (cycles !== 5) begin n_bad++; $display("FAIL t3_duration: got %0d want 5", cycles); end
      n_cmp++; if ({num_inputs, fail_count, busy} !== 9'd0) begin n_bad++; $display("FAIL t3_after: got num=%0d fail=%0d busy=%b want 0 0 0", num_inputs, fail_count, busy); end
      enter_code(4, PW);
      run_compare(1'b0, PW, 4'd4, m, mm, bad);
      n_cmp++; if ({m, mm, bad} !== 3'b100) begin n_bad++; $display("FAIL t3_match: got %b want 100", {m, mm, bad}); end
   endtask
   task automatic test_overflow();
      enter_code(8, 16'hE4E4);
      n_cmp++; if ({num_inputs, overflow} !== 5'b1000_0) begin n_bad++; $display("FAIL t4_full: got num=%0d ovf=%b want 8 0", num_inputs, overflow); end
      strobe(2'd1);
      n_cmp++; if ({num_inputs, overflow} !== 5'b1000_1) begin n_bad++; $display("FAIL t4_ovf: got num=%0d ovf=%b want 8 1", num_inputs, overflow); end
      clear = 1'b1;
      step();
      clear = 1'b0;
      n_cmp++; if ({num_inputs, overflow} !== 5'b0000_0) begin n_bad++; $display("FAIL t4_clear: got num=%0d ovf=%b want 0 0", num_inputs, overflow); end
   endtask
   task automatic test_boundaries();
      logic m, mm, bad;
      enter_code(3, PW);
      run_compare(1'b1, PW, 4'd4, m, mm, bad);
      n_cmp++; if ({m, mm, bad} !== 3'b010) begin n_bad++; $display("FAIL t5_same_cycle: got %b want 010", {m, mm, bad}); end
      enter_code(4, PW);
      run_compare(1'b0, 16'h0000, 4'd2, m, mm, bad);
      n_cmp++; if ({m, mm, bad} !== 3'b100) begin n_bad++; $display("FAIL t5_pw_change: got %b want 100", {m, mm, bad}); end
      pw_length = 4'd0;
      run_compare(1'b0, PW, 4'd0, m, mm, bad);
      n_cmp++; if ({m, mm, bad} !== 3'b010) begin n_bad++; $display("FAIL t5_len0: got %b want 010", {m, mm, bad}); end
      pw_length = 4'd4;
      enter_code(4, 16'h0067);
      run_compare(1'b0, PW, 4'd4, m, mm, bad);
      n_cmp++; if ({m, mm, fail_count} !== 6'b01_0010) begin n_bad++; $display("FAIL t5_wrong_digit: got %b want 010010", {m, mm, fail_count}); end
      enter_code(4, PW);
      run_compare(1'b0, PW, 4'd4, m, mm, bad);
      n_cmp++; if ({m, mm, fail_count} !== 6'b10_0000) begin n_bad++; $display("FAIL t5_correct: got %b want 100000", {m, mm, fail_count}); end
   endtask
   task automatic test_reset_mid_check();
      logic m, mm, bad;
      logic seen;
      enter_code(1, PW);
      run_compare(1'b0, PW, 4'd4, m, mm, bad);
      n_cmp++; if (fail_count !== 4'd1) begin n_bad++; $display("FAIL t6_pre_fail: got %0d want 1", fail_count); end
      enter_code(4, PW);
      compare = 1'b1;
      step();
      compare = 1'b0;
      step();
      step();
      step();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t6_busy_before: got %b want 1", busy); end
      reset = 1'b1;
      #1;
      n_cmp++; if ({num_inputs, overflow, busy, match, mismatch, locked, fail_count} !== 13'd0) begin n_bad++; $display("FAIL t6_async: got %h want 0", {num_inputs, overflow, busy, match, mismatch, locked, fail_count}); end
      step();
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (match !== 1'b0 || mismatch !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL t6_no_pulse: got %b want 0", seen); end
      n_cmp++; if ({num_inputs, fail_count, locked, overflow} !== 10'd0) begin n_bad++; $display("FAIL t6_idle: got num=%0d fail=%0d locked=%b ovf=%b want 0", num_inputs, fail_count, locked, overflow); end
   endtask
   initial begin
      test_reset();
      test_match();
      test_mismatch();
      test_lockout();
      test_overflow();
      test_boundaries();
      test_reset_mid_check();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
